// File: rtl/aes_pkg.sv
// Shared AES helpers: FSM state encoding, round constants, forward S-box and
// GF(2^8) arithmetic used by both the iterative decryptor and the encryptor.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    DEC  = 2'd2,
    DONE = 2'd3
  } aes_state_t;

  // Byte b of the table sits at bits [(255-b)*8 +: 8], i.e. base {~b, 3'b000}.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon[1..10]; indices outside that range never occur in the datapath.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    mul9 = x8 ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    mulb = x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    muld = x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    mule = x8 ^ x4 ^ x2;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    inv_mix_col = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                   mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                   muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                   mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in and one byte out.
module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] INV_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = INV_TABLE[{~a, 3'b000} +: 8];

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: 10 cycles of forward key expansion to reach rk10,
// then 10 inverse rounds that unwind the key schedule alongside the state.
module aes128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data,
  input  logic [127:0] key128,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out128
);

  aes_state_t   fsm;
  logic [127:0] state;
  logic [127:0] rk;
  logic [3:0]   cnt;

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] addk;
  logic [127:0] mixed;
  logic [127:0] rk_fwd;
  logic [127:0] rk_bwd;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] b1, b2, b3;
  logic [31:0] sw_in, sw_t;
  logic [31:0] f0, f1, f2, f3;

  assign w0 = rk[127:96];
  assign w1 = rk[95:64];
  assign w2 = rk[63:32];
  assign w3 = rk[31:0];

  assign b3 = w3 ^ w2;
  assign b2 = w2 ^ w1;
  assign b1 = w1 ^ w0;

  // One set of four forward S-boxes serves both directions of the key schedule:
  // forward uses w3 of rk(i), backward uses the recovered w3 of rk(r).
  assign sw_in = (fsm == DEC) ? b3 : w3;
  assign sw_t  = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon(cnt + 4'd1), 24'h000000};

  assign f0 = w0 ^ sw_t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign rk_fwd = {f0, f1, f2, f3};
  assign rk_bwd = {w0 ^ sw_t, b1, b2, b3};

  genvar gc, gr, gi;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign shifted[127-8*(4*gc+gr) -: 8] = state[127-8*(4*((gc-gr+4)%4)+gr) -: 8];
      end
      assign mixed[127-32*gc -: 32] = inv_mix_col(addk[127-32*gc -: 32]);
    end
    for (gi = 0; gi < 16; gi++) begin : g_isb
      aes_inv_sbox u_isb (
        .a(shifted[127-8*gi -: 8]),
        .y(subbed[127-8*gi -: 8])
      );
    end
  endgenerate

  assign addk   = subbed ^ rk_bwd;
  assign out128 = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      state     <= '0;
      rk        <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state    <= data;
            rk       <= key128;
            cnt      <= '0;
            in_ready <= 1'b0;
            fsm      <= KEXP;
          end
        end
        KEXP: begin
          rk <= rk_fwd;
          if (cnt == 4'd9) begin
            state <= state ^ rk_fwd;
            fsm   <= DEC;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          rk <= rk_bwd;
          if (cnt == 4'd0) begin
            state     <= addk;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            state <= mixed;
            cnt   <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Scoreboard bench for aes128_decrypt_iter: FIPS-197 vectors, hold/abort cases,
// and back-to-back round-trips against a behavioural AES-128 encryptor.
module tb_aes128_decrypt_iter;
  import aes_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data;
  logic [127:0] key128;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out128;

  int n_vec;
  int n_err;
  int cyc;
  int accept_cyc;
  logic [127:0] sb[$];

  localparam int NJOB = 1000;

  aes128_decrypt_iter dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data(data),
    .key128(key128),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out128(out128)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "[TB] watchdog");
  end

  // Behavioural encryptor used to produce ciphertexts for round-trip jobs.
  function automatic logic [127:0] enc_model(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, t, rk;
    logic [31:0]  w0, w1, w2, w3, tw;
    logic [7:0]   rc, a0, a1, a2, a3;
    s  = p ^ k;
    rk = k;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
      tw = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      w0 = w0 ^ tw; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rk = {w0, w1, w2, w3};
      rc = xtime(rc);
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          t[127-8*(4*c+rr) -: 8] = s[127-8*(4*((c+rr)%4)+rr) -: 8];
      s = t;
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
      end
      s = s ^ rk;
    end
    return s;
  endfunction

  task automatic compare(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    compare("ready_before_job", {127'd0, in_ready}, 128'd1);
    sb.push_back(p);
    key128   = k;
    data     = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    logic [127:0] exp;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    compare({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    compare({tag, "_latency"}, 128'(cyc - accept_cyc), 128'd20);
    if (sb.size() == 0) begin
      compare({tag, "_queue"}, 128'd0, 128'd1);
    end else begin
      exp = sb.pop_front();
      compare(tag, out128, exp);
    end
  endtask

  task automatic releaseOutput(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    compare({tag, "_ready_after"}, {127'd0, in_ready}, 128'd1);
    compare({tag, "_valid_after"}, {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    logic [127:0] held, k, p, c;
    int sent, got, last_out, saw;
    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data = '0; key128 = '0;
    #2 rst_n = 1'b0;
    #1;
    compare("reset_in_ready", {127'd0, in_ready}, 128'd1);
    compare("reset_out_valid", {127'd0, out_valid}, 128'd0);
    compare("reset_out128", out128, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] FIPS-197 and SP800-38A vectors");
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff);
    checkOutput("fips197");
    releaseOutput("fips197");
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                  128'h6bc1bee22e409f96e93d7e117393172a);
    checkOutput("sp800");
    releaseOutput("sp800");
    applyStimulus(128'd0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'd0);
    checkOutput("zero_key");

    $display("[TB] hold with out_ready low while in_valid toggles");
    held = out128;
    for (int i = 0; i < 50; i++) begin
      in_valid = ~in_valid;
      data     = {$urandom, $urandom, $urandom, $urandom};
      key128   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      compare("hold_out128", out128, held);
      compare("hold_in_ready", {127'd0, in_ready}, 128'd0);
      compare("hold_out_valid", {127'd0, out_valid}, 128'd1);
    end
    in_valid = 1'b0;
    releaseOutput("hold");
    @(posedge clk); #1;
    compare("hold_no_second_job", {127'd0, in_ready}, 128'd1);

    $display("[TB] reset during DEC");
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff);
    void'(sb.pop_front());
    repeat (16) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    compare("abort_out_valid", {127'd0, out_valid}, 128'd0);
    compare("abort_in_ready", {127'd0, in_ready}, 128'd1);
    compare("abort_out128", out128, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) saw++;
    end
    compare("abort_no_pulse", 128'(saw), 128'd0);
    applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff);
    checkOutput("after_abort");
    releaseOutput("after_abort");

    $display("[TB] back-to-back random round-trips");
    sent = 0; got = 0; last_out = 0;
    out_ready = 1'b1;
    for (int t = 0; t < NJOB * 22 + 200 && got < NJOB; t++) begin
      if (in_ready && sent < NJOB) begin
        k = {$urandom, $urandom, $urandom, $urandom};
        p = {$urandom, $urandom, $urandom, $urandom};
        c = enc_model(k, p);
        key128 = k; data = c; in_valid = 1'b1;
        sb.push_back(p);
        sent++;
      end else if (sent >= NJOB) begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        if (sb.size() == 0) compare("b2b_queue", 128'd0, 128'd1);
        else compare("b2b_data", out128, sb.pop_front());
        if (got > 0) compare("b2b_period", 128'(cyc - last_out), 128'd22);
        last_out = cyc;
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    compare("b2b_count", 128'(got), 128'(NJOB));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
